// File: rtl/imm_generator_pkg.sv
// Shared RV32I opcode encodings and widths for the decode-stage immediate generator.
package imm_generator_pkg;

    localparam int unsigned OPCODE_WIDTH = 7;
    localparam int unsigned INST_WIDTH   = 32;
    localparam int unsigned IMM_WIDTH    = 32;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        R_type       = 7'b0110011,
        I_type_load  = 7'b0000011,
        I_type_arth  = 7'b0010011,
        S_type       = 7'b0100011,
        SB_type      = 7'b1100011,
        JALR         = 7'b1100111,
        U_type_lui   = 7'b0110111,
        U_type_auipc = 7'b0010111,
        UJ_type      = 7'b1101111
    } opcode_e;

endpackage

// File: rtl/imm_generator_extract.sv
// Combinational opcode-to-immediate mux; pure bit wiring with sign extension from inst[31].
// Define IMM_GEN_UJ_EN to decode LUI/AUIPC/JAL/JALR; otherwise they yield 0.
module imm_extract
    import imm_generator_pkg::*;
(
    input  logic [INST_WIDTH-1:0] inst,
    output logic [IMM_WIDTH-1:0]  imm_c
);

    logic [OPCODE_WIDTH-1:0] opcode;
    logic                    sign;

    assign opcode = inst[OPCODE_WIDTH-1:0];
    assign sign   = inst[31];

    always_comb begin
        imm_c = '0;
        case (opcode)
            I_type_load,
            I_type_arth: imm_c = {{20{sign}}, inst[31:20]};
            S_type:      imm_c = {{20{sign}}, inst[31:25], inst[11:7]};
            SB_type:     imm_c = {{19{sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
`ifdef IMM_GEN_UJ_EN
            JALR:         imm_c = {{20{sign}}, inst[31:20]};
            U_type_lui,
            U_type_auipc: imm_c = {inst[31:12], 12'b0};
            UJ_type:      imm_c = {{11{sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`endif
            default:     imm_c = '0;
        endcase
    end

`ifndef IMM_GEN_UJ_EN
    // inst[19:12] only feeds the U/UJ formats, which are compiled out here.
    logic unused_u_bits;
    assign unused_u_bits = ^inst[19:12];
`endif

endmodule

// File: rtl/imm_generator.sv
// Decode-stage immediate generator: combinational extract plus one output register.
// Optional U/UJ/JALR decode is enabled by defining IMM_GEN_UJ_EN.
module imm_generator
    import imm_generator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INST_WIDTH-1:0] Instruction_code,
    output logic [IMM_WIDTH-1:0]  generated_immediate
);

    logic [IMM_WIDTH-1:0] imm_c;

    imm_extract u_extract (
        .inst  (Instruction_code),
        .imm_c (imm_c)
    );

    // Single pipeline stage aligning the immediate with the other decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            generated_immediate <= '0;
        end else begin
            generated_immediate <= imm_c;
        end
    end

endmodule

// File: tb/tb_imm_generator.sv
// Directed, table-driven bench for imm_generator; expectations follow IMM_GEN_UJ_EN.
module tb_imm_generator;
    import imm_generator_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] imm;

    int tests_run;
    int tests_failed;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    imm_generator dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .Instruction_code    (inst),
        .generated_immediate (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] uj(input logic [31:0] v);
`ifdef IMM_GEN_UJ_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{"r_type",      {12'd66, 5'd3, 3'd0, 5'd7, R_type},                       32'h0};
        vecs[1]  = '{"load_24",     {12'd24, 5'd1, 3'd2, 5'd2, I_type_load},                  32'd24};
        vecs[2]  = '{"load_m4",     {12'hFFC, 5'd1, 3'd2, 5'd2, I_type_load},                 32'hFFFF_FFFC};
        vecs[3]  = '{"arth_5",      {12'd5, 5'd4, 3'd0, 5'd6, I_type_arth},                   32'd5};
        vecs[4]  = '{"arth_m4",     {12'hFFC, 5'h1F, 3'd7, 5'h1F, I_type_arth},               32'hFFFF_FFFC};
        vecs[5]  = '{"s_44",        {12'b000000100100, 5'd0, 3'd2, 5'b01100, S_type},         32'd44};
        vecs[6]  = '{"s_12",        {12'd16, 5'd0, 3'd2, 5'b01100, S_type},                   32'd12};
        vecs[7]  = '{"s_m1",        {7'h7F, 5'd0, 5'd0, 3'd0, 5'h1F, S_type},                 32'hFFFF_FFFF};
        vecs[8]  = '{"sb_2152",     {12'b000001111000, 5'd0, 3'd0, 5'b01001, SB_type},        32'd2152};
        vecs[9]  = '{"sb_m20",      {12'b111111100000, 5'd0, 3'd0, 5'b01101, SB_type},        32'hFFFF_FFEC};
        vecs[10] = '{"lui",         32'hABCD_E0B7,                                            uj(32'hABCD_E000)};
        vecs[11] = '{"auipc",       {20'h80000, 5'd3, U_type_auipc},                          uj(32'h8000_0000)};
        vecs[12] = '{"jal_m2",      32'hFFFF_F06F,                                            uj(32'hFFFF_FFFE)};
        vecs[13] = '{"jal_6146",    {1'b0, 10'd1, 1'b1, 8'd1, 5'd1, UJ_type},                 uj(32'd6146)};
        vecs[14] = '{"jalr_m4",     {12'hFFC, 5'd1, 3'd0, 5'd1, JALR},                        uj(32'hFFFF_FFFC)};
        vecs[15] = '{"unlisted",    32'hFFFF_FFFF,                                            32'h0};

        // Reset state: output cleared while rst_n is low, even with a live instruction.
        rst_n = 1'b0;
        inst  = {12'hFFC, 5'd1, 3'd2, 5'd2, I_type_load};
        repeat (2) @(posedge clk);
        #1 check("reset_hold", imm, 32'h0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1 check("first_capture", imm, 32'hFFFF_FFFC);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk) inst = vecs[i].inst;
            @(posedge clk) #1 check(vecs[i].name, imm, vecs[i].exp);
        end

        // Output holds the previous capture until the next rising edge.
        @(negedge clk) inst = {12'd24, 5'd1, 3'd2, 5'd2, I_type_load};
        @(posedge clk) #1;
        @(negedge clk) inst = {12'd5, 5'd4, 3'd0, 5'd6, I_type_arth};
        #1 check("hold_until_edge", imm, 32'd24);
        @(posedge clk) #1 check("next_edge", imm, 32'd5);

        // Mid-stream asynchronous reset discards the registered -4.
        @(negedge clk) inst = {12'hFFC, 5'd1, 3'd2, 5'd2, I_type_load};
        @(posedge clk) #1 check("pre_reset", imm, 32'hFFFF_FFFC);
        #2 rst_n = 1'b0;
        #1 check("async_reset", imm, 32'h0);
        @(posedge clk) #1 check("reset_held", imm, 32'h0);
        @(negedge clk) begin
            inst  = {12'd5, 5'd4, 3'd0, 5'd6, I_type_arth};
            rst_n = 1'b1;
        end
        #1 check("no_replay", imm, 32'h0);
        @(posedge clk) #1 check("post_reset_capture", imm, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
